// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war playfield: winner/state encodings and the
// position-width helper used to size the lit-light index.
package tug_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } winner_t;

    typedef enum logic {
        PLAY = 1'b0,
        WIN  = 1'b1
    } state_t;

    function automatic int pos_width(input int num_lights);
        return (num_lights > 1) ? $clog2(num_lights) : 1;
    endfunction

endpackage

// File: rtl/key_pulse.sv
// Registers one already-synchronised key level and emits a single-cycle pulse
// on its rising edge; a held key therefore yields exactly one pulse.
module key_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;
    logic level_d;

    always_comb begin
        level_d = level;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/tug_light_bar.sv
// Tug-of-war playfield: lit position, PLAY/WIN FSM and saturating per-side scores.
// Optional auto restart after a win is enabled by defining TUG_AUTO_RESTART_EN.
module tug_light_bar
    import tug_pkg::*;
#(
    parameter int NUM_LIGHTS     = 9,
    parameter int SCORE_W        = 3,
    parameter int RESTART_CYCLES = 50
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  L,
    input  logic                  R,
    input  logic                  restart,
    output logic [NUM_LIGHTS-1:0] lights,
    output winner_t               winner,
    output logic [SCORE_W-1:0]    left_score,
    output logic [SCORE_W-1:0]    right_score
);

    localparam int                 POS_W     = pos_width(NUM_LIGHTS);
    localparam logic [POS_W-1:0]   CENTER    = POS_W'(NUM_LIGHTS / 2);
    localparam logic [POS_W-1:0]   LAST      = POS_W'(NUM_LIGHTS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    // Reject configurations that would break the symmetric centre start.
    if (NUM_LIGHTS < 3 || (NUM_LIGHTS % 2) == 0 || RESTART_CYCLES < 1 || SCORE_W < 1)
    begin : g_bad_param
        $error("tug_light_bar: illegal parameter combination");
    end

    logic pulse_l;
    logic pulse_r;
    logic move_l;
    logic move_r;
    logic auto_done;

    key_pulse u_key_l (
        .clk   (clk),
        .reset (reset),
        .level (L),
        .pulse (pulse_l)
    );

    key_pulse u_key_r (
        .clk   (clk),
        .reset (reset),
        .level (R),
        .pulse (pulse_r)
    );

    // Simultaneous presses cancel and are consumed by the edge detectors.
    assign move_l = pulse_l & ~pulse_r;
    assign move_r = pulse_r & ~pulse_l;

    state_t               state_q,       state_d;
    winner_t              winner_q,      winner_d;
    logic [POS_W-1:0]     pos_q,         pos_d;
    logic [SCORE_W-1:0]   left_score_q,  left_score_d;
    logic [SCORE_W-1:0]   right_score_q, right_score_d;

`ifdef TUG_AUTO_RESTART_EN
    localparam int CNT_W = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESTART_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero outside WIN so every win starts a fresh display period.
    always_comb begin
        cnt_d = '0;
        if (state_q == WIN && cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign auto_done = (state_q == WIN) && (cnt_q == CNT_LAST);
`else
    assign auto_done = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        pos_d         = pos_q;
        left_score_d  = left_score_q;
        right_score_d = right_score_q;
        unique case (state_q)
            PLAY: begin
                if (restart) begin
                    pos_d = CENTER;
                end else if (move_l) begin
                    if (pos_q == LAST) begin
                        state_d  = WIN;
                        winner_d = LEFT;
                        if (left_score_q != SCORE_MAX) begin
                            left_score_d = left_score_q + 1'b1;
                        end
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else if (move_r) begin
                    if (pos_q == '0) begin
                        state_d  = WIN;
                        winner_d = RIGHT;
                        if (right_score_q != SCORE_MAX) begin
                            right_score_d = right_score_q + 1'b1;
                        end
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end
            WIN: begin
                if (restart || auto_done) begin
                    state_d  = PLAY;
                    winner_d = NONE;
                    pos_d    = CENTER;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= PLAY;
            winner_q      <= NONE;
            pos_q         <= CENTER;
            left_score_q  <= '0;
            right_score_q <= '0;
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            pos_q         <= pos_d;
            left_score_q  <= left_score_d;
            right_score_q <= right_score_d;
        end
    end

    for (genvar gi = 0; gi < NUM_LIGHTS; gi++) begin : g_lights
        assign lights[gi] = (pos_q == POS_W'(gi));
    end

    assign winner      = winner_q;
    assign left_score  = left_score_q;
    assign right_score = right_score_q;

endmodule
